// File: rtl/dm_pkg.sv
// Shared sizing and types for the MEM-stage data memory.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package dm_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 256;
  localparam int IDX_W  = $clog2(DEPTH);

  typedef logic [DATA_W-1:0] data_word_t;

endpackage

// File: rtl/dm_storage_array.sv
// DEPTH x DATA_W register array with a sync-clear and one write port.
// Latency: writes land on the rising clk edge; the raw read port is combinational.
// Backpressure: none; every write completes in the cycle it is presented.
module dm_storage_array
  import dm_pkg::*;
#(
  parameter int DATA_W = dm_pkg::DATA_W,
  parameter int DEPTH  = dm_pkg::DEPTH,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_vld,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_dat
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Reset wins over a same-cycle write; an X/Z enable falls through the if as no-write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_vld) begin
      mem[wr_idx] <= wr_dat;
    end
  end

  assign rd_dat = mem[rd_idx];

endmodule

// File: rtl/data_memory.sv
// Word-addressed data memory: async read gated by memread, sync write, sync clear.
// Latency: read is zero-cycle combinational; write visible after the next rising clk.
// Backpressure: none; no handshake or stall, every access finishes in one cycle.
module data_memory
  import dm_pkg::*;
#(
  parameter int DATA_W = dm_pkg::DATA_W,
  parameter int ADDR_W = dm_pkg::ADDR_W,
  parameter int DEPTH  = dm_pkg::DEPTH,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              memread,
  input  logic              memwrite,
  output logic [DATA_W-1:0] read_data
);

  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] raw_rd_dat;
  logic              addr_hi_unused;

  // Upper address bits are dropped so accesses wrap modulo DEPTH.
  assign idx            = addr[IDX_W-1:0];
  assign addr_hi_unused = ^addr[ADDR_W-1:IDX_W];

  dm_storage_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_storage (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (memwrite),
    .wr_idx (idx),
    .wr_dat (write_data),
    .rd_idx (idx),
    .rd_dat (raw_rd_dat)
  );

  assign read_data = memread ? raw_rd_dat : '0;

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory.
module tb_data_memory;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        memread;
  logic        memwrite;
  logic [31:0] read_data;

  int errors;
  int checks;

  data_memory dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .write_data (write_data),
    .memread    (memread),
    .memwrite   (memwrite),
    .read_data  (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus only: one write edge, inputs moved 1ns after the edge.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    addr       = a;
    write_data = d;
    memwrite   = 1'b1;
    @(posedge clk);
    #1;
    memwrite   = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] addrs [3];
    addrs = '{32'd0, 32'd1, 32'd255};
    rst = 1'b1;
    memwrite = 1'b0;
    memread = 1'b0;
    addr = '0;
    write_data = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    memread = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr = addrs[i];
      #1;
      checks++;
      if (read_data !== 32'h0) begin
        errors++;
        $display("FAIL reset_clear addr=%0d got=%h exp=%h", addrs[i], read_data, 32'h0);
      end
    end
  endtask

  task automatic test_write_read();
    memread = 1'b0;
    do_write(32'd1, 32'hFFFF_FFFE);
    memread = 1'b1;
    addr = 32'd1;
    #1;
    checks++;
    if (read_data !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL write_read addr=1 got=%h exp=%h", read_data, 32'hFFFF_FFFE);
    end
  endtask

  task automatic test_same_cycle();
    memread = 1'b1;
    memwrite = 1'b1;
    addr = 32'd2;
    write_data = 32'hFFFF_FFFD;
    #1;
    checks++;
    if (read_data !== 32'h0) begin
      errors++;
      $display("FAIL same_cycle_before got=%h exp=%h", read_data, 32'h0);
    end
    @(posedge clk);
    #1;
    memwrite = 1'b0;
    #1;
    checks++;
    if (read_data !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL same_cycle_after got=%h exp=%h", read_data, 32'hFFFF_FFFD);
    end
  endtask

  task automatic test_independence();
    logic [31:0] addrs [5];
    logic [31:0] exps  [5];
    addrs = '{32'd1, 32'd2, 32'd4, 32'd8, 32'd3};
    exps  = '{32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'hFFFF_FFF7, 32'h0};
    memread = 1'b0;
    do_write(32'd4, 32'hFFFF_FFFB);
    do_write(32'd8, 32'hFFFF_FFF7);
    memread = 1'b1;
    for (int i = 0; i < 5; i++) begin
      addr = addrs[i];
      #1;
      checks++;
      if (read_data !== exps[i]) begin
        errors++;
        $display("FAIL independence addr=%0d got=%h exp=%h", addrs[i], read_data, exps[i]);
      end
    end
  endtask

  task automatic test_gating_wrap();
    memread = 1'b0;
    addr = 32'd1;
    #1;
    checks++;
    if (read_data !== 32'h0) begin
      errors++;
      $display("FAIL gating addr=1 got=%h exp=%h", read_data, 32'h0);
    end
    do_write(32'h0000_0105, 32'hA5A5_A5A5);
    memread = 1'b1;
    addr = 32'd5;
    #1;
    checks++;
    if (read_data !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL wrap_write addr=5 got=%h exp=%h", read_data, 32'hA5A5_A5A5);
    end
    addr = 32'h8000_0205;
    #1;
    checks++;
    if (read_data !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL wrap_read addr=80000205 got=%h exp=%h", read_data, 32'hA5A5_A5A5);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] addrs [6];
    addrs = '{32'd1, 32'd2, 32'd4, 32'd8, 32'd9, 32'd5};
    memread = 1'b0;
    rst = 1'b1;
    memwrite = 1'b1;
    addr = 32'd9;
    write_data = 32'h1234_5678;
    @(posedge clk);
    #1;
    rst = 1'b0;
    memwrite = 1'b0;
    memread = 1'b1;
    for (int i = 0; i < 6; i++) begin
      addr = addrs[i];
      #1;
      checks++;
      if (read_data !== 32'h0) begin
        errors++;
        $display("FAIL reset_mid addr=%0d got=%h exp=%h", addrs[i], read_data, 32'h0);
      end
    end
  endtask

  task automatic test_x_write();
    memread = 1'b1;
    addr = 32'd7;
    write_data = 32'hDEAD_BEEF;
    memwrite = 1'bx;
    @(posedge clk);
    #1;
    memwrite = 1'b0;
    #1;
    checks++;
    if (read_data !== 32'h0) begin
      errors++;
      $display("FAIL x_memwrite addr=7 got=%h exp=%h", read_data, 32'h0);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_write_read();
    test_same_cycle();
    test_independence();
    test_gating_wrap();
    test_reset_mid();
    test_x_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
